queue_reg: RTL and testbench

//  First-in/first-out register file for the Synapse core: the opposite-end

---
 rtl/queue_reg.sv | 103 ++++++++++
 tb/tb_queue_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/queue_reg.sv
// Register-mapped FIFO: producer pushes at the tail, consumer pops from the head.
// Head word is visible combinationally; fill level and sticky error flags are reported.
module queue_reg #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             read,
    input  logic             flush,
    input  logic             clear_err,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic do_push, do_pop, ovf_evt, unf_evt;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign data_out  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop on the same edge frees the slot, so a full queue can still accept a push.
    assign do_push = !flush && load && (!full || read);
    assign do_pop  = !flush && read && !empty;
    assign ovf_evt = !flush && load && !read && full;
    assign unf_evt = !flush && read && empty;

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end

        // New error events take precedence over a same-cycle clear.
        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_evt) overflow_d  = 1'b1;
        if (unf_evt) underflow_d = 1'b1;
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_queue_reg.sv
// Directed bench for queue_reg: DEPTH=8 instance for fill/drain/error/flush,
// DEPTH=5 instance for pointer wrap against a scoreboard queue.
module tb_queue_reg;

    logic        sysclk = 1'b0;
    logic        sysreset;

    logic [15:0] data_in;
    logic        load, read, flush, clear_err;
    logic [15:0] data_out;
    logic [3:0]  count;
    logic        empty, full, overflow, underflow;

    logic [15:0] din5;
    logic        load5, read5;
    logic        flush5 = 1'b0;
    logic        clr5 = 1'b0;
    logic [15:0] dout5;
    logic [2:0]  cnt5;
    logic        empty5, full5, ovf5, unf5;

    int n_vec = 0;
    int n_err = 0;

    always #5 sysclk = ~sysclk;

    queue_reg #(.DEPTH(8), .WIDTH(16)) u_q8 (
        .sysclk(sysclk), .sysreset(sysreset), .data_in(data_in), .load(load),
        .read(read), .flush(flush), .clear_err(clear_err), .data_out(data_out),
        .count(count), .empty(empty), .full(full), .overflow(overflow),
        .underflow(underflow)
    );

    queue_reg #(.DEPTH(5), .WIDTH(16)) u_q5 (
        .sysclk(sysclk), .sysreset(sysreset), .data_in(din5), .load(load5),
        .read(read5), .flush(flush5), .clear_err(clr5), .data_out(dout5),
        .count(cnt5), .empty(empty5), .full(full5), .overflow(ovf5),
        .underflow(unf5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic push8(input logic [15:0] w);
        data_in = w; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic fill8();
        for (int k = 1; k <= 8; k++) push8(16'(k * 16'h1111));
    endtask

    logic [15:0] sb [$];
    logic [15:0] w;

    initial begin
        sysreset = 1'b1;
        data_in = '0; load = 0; read = 0; flush = 0; clear_err = 0;
        din5 = '0; load5 = 0; read5 = 0;
        tick(); tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_flags", {30'd0, overflow, underflow}, 0);
        sysreset = 1'b0;
        tick();

        // 1: asynchronous reset mid-fill
        read = 1'b1; tick(); read = 1'b0;
        chk("t1_unf_set", 32'(underflow), 1);
        push8(16'h0A01); push8(16'h0A02); push8(16'h0A03);
        chk("t1_count3", 32'(count), 3);
        chk("t1_head", 32'(data_out), 32'h0A01);
        #2 sysreset = 1'b1;
        #1;
        chk("t1_rst_count", 32'(count), 0);
        chk("t1_rst_empty", 32'(empty), 1);
        chk("t1_rst_dout", 32'(data_out), 0);
        chk("t1_rst_flags", {30'd0, overflow, underflow}, 0);
        tick();
        sysreset = 1'b0;
        tick();

        // 2: fill and drain in order
        fill8();
        chk("t2_full", 32'(full), 1);
        chk("t2_count8", 32'(count), 8);
        read = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("t2_drain", 32'(data_out), 32'(k * 16'h1111));
            tick();
        end
        read = 1'b0;
        chk("t2_empty", 32'(empty), 1);
        chk("t2_dout0", 32'(data_out), 0);
        chk("t2_count0", 32'(count), 0);

        // 3: overflow, set-wins-over-clear, push+pop at full
        fill8();
        push8(16'hDEAD);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_count", 32'(count), 8);
        chk("t3_head", 32'(data_out), 32'h1111);
        clear_err = 1'b1; data_in = 16'hDEAD; load = 1'b1;
        tick();
        load = 1'b0;
        chk("t3_setwins", 32'(overflow), 1);
        tick();
        clear_err = 1'b0;
        chk("t3_clr", 32'(overflow), 0);
        data_in = 16'hBEEF; load = 1'b1; read = 1'b1;
        tick();
        load = 1'b0; read = 1'b0;
        chk("t3_rw_count", 32'(count), 8);
        chk("t3_rw_noovf", 32'(overflow), 0);
        read = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk("t3_order", 32'(data_out), (k == 9) ? 32'hBEEF : 32'(k * 16'h1111));
            tick();
        end
        read = 1'b0;
        chk("t3_empty", 32'(empty), 1);

        // 4: underflow, then push+pop on empty
        read = 1'b1; tick(); read = 1'b0;
        chk("t4_unf", 32'(underflow), 1);
        chk("t4_count", 32'(count), 0);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("t4_clr", 32'(underflow), 0);
        data_in = 16'h00A5; load = 1'b1; read = 1'b1;
        tick();
        load = 1'b0; read = 1'b0;
        chk("t4_count1", 32'(count), 1);
        chk("t4_dout", 32'(data_out), 32'h00A5);
        chk("t4_unf2", 32'(underflow), 1);
        read = 1'b1; clear_err = 1'b1; tick(); read = 1'b0; clear_err = 1'b0;
        chk("t4_drained", 32'(empty), 1);

        // 6: flush beats a same-cycle load and read
        push8(16'h0601); push8(16'h0602); push8(16'h0603); push8(16'h0604);
        chk("t6_count4", 32'(count), 4);
        flush = 1'b1; load = 1'b1; read = 1'b1; data_in = 16'h0BAD;
        tick();
        flush = 1'b0; load = 1'b0; read = 1'b0;
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_dout0", 32'(data_out), 0);
        chk("t6_flags", {30'd0, overflow, underflow}, 0);
        push8(16'h0042);
        chk("t6_dout", 32'(data_out), 32'h0042);
        chk("t6_count1", 32'(count), 1);

        // 5: DEPTH=5 wrap with simultaneous push/pop against a scoreboard
        for (int k = 0; k < 2; k++) begin
            w = 16'($urandom);
            din5 = w; load5 = 1'b1; sb.push_back(w);
            tick();
        end
        load5 = 1'b0;
        chk("t5_count2", 32'(cnt5), 2);
        for (int k = 0; k < 12; k++) begin
            w = 16'($urandom);
            chk("t5_head", 32'(dout5), 32'(sb[0]));
            din5 = w; load5 = 1'b1; read5 = 1'b1;
            tick();
            void'(sb.pop_front());
            sb.push_back(w);
            chk("t5_count", 32'(cnt5), 2);
        end
        load5 = 1'b0; read5 = 1'b0;
        read5 = 1'b1;
        while (sb.size() > 0) begin
            chk("t5_drain", 32'(dout5), 32'(sb[0]));
            tick();
            void'(sb.pop_front());
        end
        read5 = 1'b0;
        chk("t5_empty", 32'(empty5), 1);
        chk("t5_flags", {30'd0, ovf5, unf5}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
